permutation_inv: RTL

PERMUTATION_INV -- requirements
Module: permutation_inv

---
 rtl/ascon_pack.sv | 22 ++
 rtl/ps_inv.sv | 25 ++
 rtl/permutation_inv.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared Ascon types and constants for the inverse permutation datapath.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perm_state_e;

  // Linear-layer rotation pairs; element i belongs to word i.
  localparam logic [4:0][5:0] ROT_A = {6'd7, 6'd10, 6'd1, 6'd61, 6'd19};
  localparam logic [4:0][5:0] ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

  localparam logic [3:0] ROUND_FIRST = 4'd11;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

endpackage

// File: rtl/ps_inv.sv
// Inverse Ascon 5-bit S-box, applied bit-sliced over the 64 state columns.
module ps_inv
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  // Indexed by column value with word 0 as the MSB.
  localparam logic [31:0][4:0] SBOX_INV = {
    5'h02, 5'h10, 5'h0c, 5'h0f, 5'h08, 5'h04, 5'h1b, 5'h17,
    5'h1f, 5'h1c, 5'h05, 5'h03, 5'h11, 5'h0b, 5'h16, 5'h18,
    5'h1e, 5'h13, 5'h15, 5'h19, 5'h01, 5'h1d, 5'h06, 5'h0a,
    5'h12, 5'h0e, 5'h09, 5'h00, 5'h0d, 5'h07, 5'h1a, 5'h14
  };

  always_comb begin
    state_o = '0;
    for (int c = 0; c < 64; c++) begin
      {state_o[0][c], state_o[1][c], state_o[2][c], state_o[3][c], state_o[4][c]} =
        SBOX_INV[{state_i[0][c], state_i[1][c], state_i[2][c], state_i[3][c], state_i[4][c]}];
    end
  end

endmodule

// File: rtl/permutation_inv.sv
// Inverse Ascon permutation (p12 / p6), one inverse round per clock.
// Define PERM_INV_UNROLL2_EN to apply two inverse rounds per clock.
module permutation_inv
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      start_i,
  input  logic      rounds12_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      valid_o,
  output logic      busy_o
);
  // state | meaning
  // IDLE  | waiting for start_i
  // RUN   | applying inverse rounds, r counting down from 11
  // DONE  | state_o updated, valid_o high for this one cycle

`ifdef PERM_INV_UNROLL2_EN
  localparam logic [3:0] ROUND_STEP = 4'd2;
`else
  localparam logic [3:0] ROUND_STEP = 4'd1;
`endif
  // Round index seen in the final RUN cycle for each mode.
  localparam logic [3:0] LAST_R12 = ROUND_STEP - 4'd1;
  localparam logic [3:0] LAST_R6  = LAST_R12 + 4'd6;

  perm_state_e r_fsm;
  type_state   r_state;
  type_state   r_state_o;
  logic [3:0]  r_round;
  logic        r_mode12;

  type_state   w_lin1, w_sb1, w_rnd1, w_next;
  logic        w_last;

  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
    logic [127:0] w;
    w = {x, x} >> n;
    return w[63:0];
  endfunction

  // L = 1 + X^a + X^b satisfies L^64 = 1 modulo X^64 + 1, so L^-1 = L^63,
  // i.e. the product of the squared forms L^(2^k) for k = 0..5.
  function automatic logic [63:0] lin_inv(input logic [63:0] x, input logic [5:0] a,
                                          input logic [5:0] b);
    logic [63:0] y;
    logic [5:0]  sa;
    logic [5:0]  sb;
    y = x;
    for (int k = 0; k < 6; k++) begin
      sa = a << k;
      sb = b << k;
      y  = y ^ ror64(y, sa) ^ ror64(y, sb);
    end
    return y;
  endfunction

  always_comb begin
    w_lin1 = '0;
    for (int i = 0; i < 5; i++) w_lin1[i] = lin_inv(r_state[i], ROT_A[i], ROT_B[i]);
  end

  ps_inv u_ps_inv1 (.state_i(w_lin1), .state_o(w_sb1));

  always_comb begin
    w_rnd1          = w_sb1;
    w_rnd1[2][7:0]  = w_sb1[2][7:0] ^ round_const(r_round);
  end

`ifdef PERM_INV_UNROLL2_EN
  type_state w_lin2, w_sb2, w_rnd2;

  always_comb begin
    w_lin2 = '0;
    for (int i = 0; i < 5; i++) w_lin2[i] = lin_inv(w_rnd1[i], ROT_A[i], ROT_B[i]);
  end

  ps_inv u_ps_inv2 (.state_i(w_lin2), .state_o(w_sb2));

  always_comb begin
    w_rnd2          = w_sb2;
    w_rnd2[2][7:0]  = w_sb2[2][7:0] ^ round_const(r_round - 4'd1);
  end

  assign w_next = w_rnd2;
`else
  assign w_next = w_rnd1;
`endif

  assign w_last = (r_round == (r_mode12 ? LAST_R12 : LAST_R6));

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm     <= ST_IDLE;
      r_state   <= '0;
      r_state_o <= '0;
      r_round   <= ROUND_FIRST;
      r_mode12  <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_state  <= state_i;
            r_round  <= ROUND_FIRST;
            r_mode12 <= rounds12_i;
            r_fsm    <= ST_RUN;
          end else begin
            r_fsm <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_state <= w_next;
          if (w_last) begin
            r_state_o <= w_next;
            r_fsm     <= ST_DONE;
          end else begin
            r_round <= r_round - ROUND_STEP;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign state_o = r_state_o;
  assign valid_o = (r_fsm == ST_DONE);
  assign busy_o  = (r_fsm == ST_RUN);

endmodule
